// File: rtl/wb_commit_unit_pkg.sv
// Shared types/constants for the writeback commit stage; no logic, no latency.
// Backpressure n/a: wb_wrap folds a pointer sum (< 2*depth) back into the ring.
package wb_commit_unit_pkg;

  localparam int WB_ADDR_W      = 5;
  localparam int DEF_XLEN       = 32;
  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_BUF_DEPTH  = 4;
  localparam int DEF_LATE_DEPTH = 2;
  localparam int DEF_NUM_RS     = 2;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd_addr;
    logic [DEF_XLEN-1:0]  data;
  } wb_entry_t;

  function automatic int wb_wrap(input int idx, input int depth);
    return (idx >= depth) ? idx - depth : idx;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order collision buffer: up to NUM_ENQ compacted enqueues + one dequeue per cycle, 1-cycle write-to-read.
// No internal backpressure: caller must only enqueue when free >= popcount(enq_mask); entries exposed oldest-first.
module wb_fifo
  import wb_commit_unit_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int DEPTH   = DEF_BUF_DEPTH,
  parameter int NUM_ENQ = DEF_NUM_CH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_ENQ-1:0]                   enq_mask,
  input  logic [NUM_ENQ-1:0][WB_ADDR_W-1:0]    enq_addr,
  input  logic [NUM_ENQ-1:0][XLEN-1:0]         enq_data,
  input  logic                                 deq,
  output logic [WB_ADDR_W-1:0]                 head_addr,
  output logic [XLEN-1:0]                      head_data,
  output logic [$clog2(DEPTH+1)-1:0]           count,
  output logic [$clog2(DEPTH+1)-1:0]           free,
  output logic [DEPTH-1:0]                     ord_vld,
  output logic [DEPTH-1:0][WB_ADDR_W-1:0]      ord_addr,
  output logic [DEPTH-1:0][XLEN-1:0]           ord_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WB_ADDR_W-1:0] mem_addr [DEPTH];
  logic [XLEN-1:0]      mem_data [DEPTH];
  logic [PTR_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q;
  int                   enq_pos [NUM_ENQ];
  int                   enq_cnt;

  // Accepted lanes are packed densely behind the tail in lane order.
  always_comb begin
    enq_cnt = 0;
    for (int i = 0; i < NUM_ENQ; i++) begin
      enq_pos[i] = enq_cnt;
      if (enq_mask[i]) enq_cnt = enq_cnt + 1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENQ; i++) begin
      if (enq_mask[i]) begin
        mem_addr[PTR_W'(wb_wrap(int'(tail_q) + enq_pos[i], DEPTH))] <= enq_addr[i];
        mem_data[PTR_W'(wb_wrap(int'(tail_q) + enq_pos[i], DEPTH))] <= enq_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (deq) head_q <= PTR_W'(wb_wrap(int'(head_q) + 1, DEPTH));
      tail_q  <= PTR_W'(wb_wrap(int'(tail_q) + enq_cnt, DEPTH));
      count_q <= CNT_W'(int'(count_q) + enq_cnt - (deq ? 1 : 0));
    end
  end

  assign head_addr = mem_addr[head_q];
  assign head_data = mem_data[head_q];
  assign count     = count_q;
  assign free      = CNT_W'(DEPTH) - count_q;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ord_vld[k]  = (k < int'(count_q));
      ord_addr[k] = mem_addr[PTR_W'(wb_wrap(int'(head_q) + k, DEPTH))];
      ord_data[k] = mem_data[PTR_W'(wb_wrap(int'(head_q) + k, DEPTH))];
    end
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Merges NUM_CH result channels onto one RF write port; direct write is same-cycle, collisions drain 1/cycle in order.
// All ch_ready_o drop while fewer than NUM_CH FIFO slots are free; WB_BYPASS_HISTORY_EN adds late-bypass history.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
  parameter int LATE_DEPTH = DEF_LATE_DEPTH,
  parameter int NUM_RS     = DEF_NUM_RS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CH-1:0]                  ch_valid_i,
  output logic [NUM_CH-1:0]                  ch_ready_o,
  input  logic [NUM_CH-1:0][WB_ADDR_W-1:0]   ch_rd_addr_i,
  input  logic [NUM_CH-1:0][XLEN-1:0]        ch_rd_data_i,
  output logic                               rf_we_o,
  output logic [WB_ADDR_W-1:0]               rf_waddr_o,
  output logic [XLEN-1:0]                    rf_wdata_o,
  input  logic [NUM_RS-1:0][WB_ADDR_W-1:0]   rs_addr_i,
  output logic [NUM_RS-1:0]                  rs_hit_o,
  output logic [NUM_RS-1:0][XLEN-1:0]        rs_data_o,
  input  logic                               stall_i,
  output logic                               unstall_o,
  output logic                               busy_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH+1);

  logic [NUM_CH-1:0]                   acc, wr, enq_mask;
  logic                                deq, direct_done;
  logic [WB_ADDR_W-1:0]                head_addr;
  logic [XLEN-1:0]                     head_data;
  logic [CNT_W-1:0]                    fifo_count, fifo_free;
  logic [BUF_DEPTH-1:0]                ord_vld;
  logic [BUF_DEPTH-1:0][WB_ADDR_W-1:0] ord_addr;
  logic [BUF_DEPTH-1:0][XLEN-1:0]      ord_data;
  logic                                stall_q, unstall_q;

  wb_fifo #(
    .XLEN    (XLEN),
    .DEPTH   (BUF_DEPTH),
    .NUM_ENQ (NUM_CH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .enq_mask  (enq_mask),
    .enq_addr  (ch_rd_addr_i),
    .enq_data  (ch_rd_data_i),
    .deq       (deq),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (fifo_count),
    .free      (fifo_free),
    .ord_vld   (ord_vld),
    .ord_addr  (ord_addr),
    .ord_data  (ord_data)
  );

  always_comb begin
    ch_ready_o = {NUM_CH{int'(fifo_free) >= NUM_CH}};
    acc        = ch_valid_i & ch_ready_o;
    for (int i = 0; i < NUM_CH; i++) begin
      wr[i] = acc[i] && (ch_rd_addr_i[i] != '0);
    end
  end

  // Older buffered work always commits ahead of anything arriving now.
  always_comb begin
    rf_we_o     = 1'b0;
    rf_waddr_o  = '0;
    rf_wdata_o  = '0;
    deq         = 1'b0;
    enq_mask    = wr;
    direct_done = 1'b0;
    if (fifo_count != '0) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = head_addr;
      rf_wdata_o = head_data;
      deq        = 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr[i] && !direct_done) begin
          rf_we_o     = 1'b1;
          rf_waddr_o  = ch_rd_addr_i[i];
          rf_wdata_o  = ch_rd_data_i[i];
          enq_mask[i] = 1'b0;
          direct_done = 1'b1;
        end
      end
    end
  end

  assign busy_o = (fifo_count != '0);

`ifdef WB_BYPASS_HISTORY_EN
  logic [LATE_DEPTH-1:0]                hist_vld;
  logic [LATE_DEPTH-1:0][WB_ADDR_W-1:0] hist_addr;
  logic [LATE_DEPTH-1:0][XLEN-1:0]      hist_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_vld  <= '0;
      hist_addr <= '0;
      hist_data <= '0;
    end else if (rf_we_o) begin
      hist_vld[0]  <= 1'b1;
      hist_addr[0] <= rf_waddr_o;
      hist_data[0] <= rf_wdata_o;
      for (int k = 1; k < LATE_DEPTH; k++) begin
        hist_vld[k]  <= hist_vld[k-1];
        hist_addr[k] <= hist_addr[k-1];
        hist_data[k] <= hist_data[k-1];
      end
    end
  end
`endif

  // Scan oldest to youngest so the last match (youngest producer) wins.
  always_comb begin
    rs_hit_o  = '0;
    rs_data_o = '0;
    for (int r = 0; r < NUM_RS; r++) begin
      if (rs_addr_i[r] != '0) begin
`ifdef WB_BYPASS_HISTORY_EN
        for (int k = LATE_DEPTH-1; k >= 0; k--) begin
          if (hist_vld[k] && hist_addr[k] == rs_addr_i[r]) begin
            rs_hit_o[r]  = 1'b1;
            rs_data_o[r] = hist_data[k];
          end
        end
`endif
        for (int k = 0; k < BUF_DEPTH; k++) begin
          if (ord_vld[k] && ord_addr[k] == rs_addr_i[r]) begin
            rs_hit_o[r]  = 1'b1;
            rs_data_o[r] = ord_data[k];
          end
        end
        for (int i = 0; i < NUM_CH; i++) begin
          if (acc[i] && ch_rd_addr_i[i] == rs_addr_i[r]) begin
            rs_hit_o[r]  = 1'b1;
            rs_data_o[r] = ch_rd_data_i[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q   <= 1'b0;
      unstall_q <= 1'b0;
    end else begin
      stall_q   <= stall_i;
      unstall_q <= stall_q & ~stall_i;
    end
  end

  assign unstall_o = unstall_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed vector table, hand sequences and a queue-based reference model.
module tb_wb_commit_unit;

  localparam int XLEN       = 32;
  localparam int NUM_CH     = 2;
  localparam int BUF_DEPTH  = 4;
  localparam int LATE_DEPTH = 2;
  localparam int NUM_RS     = 2;
`ifdef WB_BYPASS_HISTORY_EN
  localparam bit HIST_EN = 1'b1;
`else
  localparam bit HIST_EN = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          rst = 1'b1;
  logic [NUM_CH-1:0]             ch_valid_i = '0;
  logic [NUM_CH-1:0]             ch_ready_o;
  logic [NUM_CH-1:0][4:0]        ch_rd_addr_i = '0;
  logic [NUM_CH-1:0][XLEN-1:0]   ch_rd_data_i = '0;
  logic                          rf_we_o;
  logic [4:0]                    rf_waddr_o;
  logic [XLEN-1:0]               rf_wdata_o;
  logic [NUM_RS-1:0][4:0]        rs_addr_i = '0;
  logic [NUM_RS-1:0]             rs_hit_o;
  logic [NUM_RS-1:0][XLEN-1:0]   rs_data_o;
  logic                          stall_i = 1'b0;
  logic                          unstall_o;
  logic                          busy_o;

  wb_commit_unit #(
    .XLEN(XLEN), .NUM_CH(NUM_CH), .BUF_DEPTH(BUF_DEPTH),
    .LATE_DEPTH(LATE_DEPTH), .NUM_RS(NUM_RS)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_valid_i(ch_valid_i), .ch_ready_o(ch_ready_o),
    .ch_rd_addr_i(ch_rd_addr_i), .ch_rd_data_i(ch_rd_data_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rs_addr_i(rs_addr_i), .rs_hit_o(rs_hit_o), .rs_data_o(rs_data_o),
    .stall_i(stall_i), .unstall_o(unstall_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic [1:0]  v;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_busy;
    logic        e_h0;
    logic [31:0] e_d0;
    logic        e_h1;
    logic [31:0] e_d1;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  ent_t mq[$];     // results accepted but not yet written, oldest first
  ent_t mh[$];     // committed writes, newest first
  ent_t got_w[$];
  logic sh1 = 1'b0, sh2 = 1'b0;
  vec_t vt[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: commit order is simply (pending queue ++ accepted channels); head of that list is written.
  task automatic model_cmp();
    ent_t acc[$];
    ent_t all[$];
    ent_t lst[$];
    ent_t w;
    logic m_rdy;
    logic eh;
    logic [31:0] ed;
    if (rst) begin
      mq.delete(); mh.delete(); sh1 = 1'b0; sh2 = 1'b0;
    end
    m_rdy = (BUF_DEPTH - mq.size()) >= NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst && ch_valid_i[i] && m_rdy && ch_rd_addr_i[i] != 5'd0) begin
        w.a = ch_rd_addr_i[i];
        w.d = ch_rd_data_i[i];
        acc.push_back(w);
      end
    end
    all = mq;
    foreach (acc[i]) all.push_back(acc[i]);
    for (int h = mh.size() - 1; h >= 0; h--) lst.push_back(mh[h]);
    foreach (all[i]) lst.push_back(all[i]);
    chk("m_ready", 64'(ch_ready_o), 64'({NUM_CH{m_rdy}}));
    chk("m_busy", 64'(busy_o), 64'(mq.size() != 0));
    chk("m_unstall", 64'(unstall_o), 64'(sh2 & ~sh1));
    chk("m_we", 64'(rf_we_o), 64'(all.size() != 0));
    if (all.size() != 0) begin
      chk("m_waddr", 64'(rf_waddr_o), 64'(all[0].a));
      chk("m_wdata", 64'(rf_wdata_o), 64'(all[0].d));
    end
    for (int j = 0; j < NUM_RS; j++) begin
      eh = 1'b0;
      ed = '0;
      if (rs_addr_i[j] != 5'd0) begin
        foreach (lst[k]) begin
          if (lst[k].a == rs_addr_i[j]) begin
            eh = 1'b1;
            ed = lst[k].d;
          end
        end
      end
      chk("m_hit", 64'(rs_hit_o[j]), 64'(eh));
      chk("m_data", 64'(rs_data_o[j]), 64'(ed));
    end
    if (all.size() != 0) begin
      if (HIST_EN) begin
        mh.push_front(all[0]);
        if (mh.size() > LATE_DEPTH) void'(mh.pop_back());
      end
      void'(all.pop_front());
    end
    mq  = all;
    sh2 = sh1;
    sh1 = stall_i;
    if (rst) begin
      mq.delete(); mh.delete(); sh1 = 1'b0; sh2 = 1'b0;
    end
  endtask

  task automatic step(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1,
                      input logic [4:0] r0, input logic [4:0] r1, input logic st);
    ent_t w;
    @(posedge clk); #1;
    ch_valid_i      = v;
    ch_rd_addr_i[0] = a0; ch_rd_data_i[0] = d0;
    ch_rd_addr_i[1] = a1; ch_rd_data_i[1] = d1;
    rs_addr_i[0]    = r0; rs_addr_i[1]    = r1;
    stall_i         = st;
    @(negedge clk);
    model_cmp();
    if (rf_we_o) begin
      w.a = rf_waddr_o;
      w.d = rf_wdata_o;
      got_w.push_back(w);
    end
  endtask

  function automatic vec_t mk(logic [1:0] v, logic [4:0] a0, logic [31:0] d0, logic [4:0] a1,
                              logic [31:0] d1, logic [4:0] r0, logic [4:0] r1, logic e_we,
                              logic [4:0] e_wa, logic [31:0] e_wd, logic e_busy, logic e_h0,
                              logic [31:0] e_d0, logic e_h1, logic [31:0] e_d1);
    vec_t x;
    x.v = v; x.a0 = a0; x.d0 = d0; x.a1 = a1; x.d1 = d1; x.r0 = r0; x.r1 = r1;
    x.e_we = e_we; x.e_wa = e_wa; x.e_wd = e_wd; x.e_busy = e_busy;
    x.e_h0 = e_h0; x.e_d0 = e_d0; x.e_h1 = e_h1; x.e_d1 = e_d1;
    return x;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  rv;
    logic [4:0]  ra0, ra1, rr0, rr1;
    logic [31:0] rd0, rd1;
    logic        rst_;

    //            v     a0  d0      a1  d1      r0  r1  we  wa  wd      busy h0 d0            h1       d1
    vt[0]  = mk(2'b00, 0,  0,      0,  0,      0,  0,  0,  0,  0,      0,   0, 0,            0,       0);
    vt[1]  = mk(2'b01, 5,  'h11,   0,  0,      5,  0,  1,  5,  'h11,   0,   1, 'h11,         0,       0);
    vt[2]  = mk(2'b11, 3,  'hA,    4,  'hB,    3,  4,  1,  3,  'hA,    0,   1, 'hA,          1,       'hB);
    vt[3]  = mk(2'b00, 0,  0,      0,  0,      4,  0,  1,  4,  'hB,    1,   1, 'hB,          0,       0);
    vt[4]  = mk(2'b00, 0,  0,      0,  0,      7,  0,  0,  0,  0,      0,   0, 0,            0,       0);
    vt[5]  = mk(2'b01, 7,  'h1,    0,  0,      7,  0,  1,  7,  'h1,    0,   1, 'h1,          0,       0);
    vt[6]  = mk(2'b11, 8,  'h9,    7,  'h2,    7,  8,  1,  8,  'h9,    0,   1, 'h2,          1,       'h9);
    vt[7]  = mk(2'b00, 0,  0,      0,  0,      7,  8,  1,  7,  'h2,    1,   1, 'h2,          HIST_EN, HIST_EN ? 'h9 : 0);
    vt[8]  = mk(2'b00, 0,  0,      0,  0,      0,  7,  0,  0,  0,      0,   0, 0,            HIST_EN, HIST_EN ? 'h2 : 0);
    vt[9]  = mk(2'b11, 0,  'h55,   9,  'h66,   0,  9,  1,  9,  'h66,   0,   0, 0,            1,       'h66);
    vt[10] = mk(2'b00, 0,  0,      0,  0,      7,  9,  0,  0,  0,      0,   HIST_EN, HIST_EN ? 'h2 : 0, HIST_EN, HIST_EN ? 'h66 : 0);
    vt[11] = mk(2'b01, 10, 'h77,   0,  0,      7,  10, 1,  10, 'h77,   0,   HIST_EN, HIST_EN ? 'h2 : 0, 1,       'h77);
    vt[12] = mk(2'b00, 0,  0,      0,  0,      7,  9,  0,  0,  0,      0,   0, 0,            HIST_EN, HIST_EN ? 'h66 : 0);
    vt[13] = mk(2'b00, 0,  0,      0,  0,      0,  0,  0,  0,  0,      0,   0, 0,            0,       0);

    // Power-on reset state
    rs_addr_i[0] = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 64'(rf_we_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_ready", 64'(ch_ready_o), 64'(2'b11));
    chk("rst_unstall", 64'(unstall_o), 64'(0));
    chk("rst_hit", 64'(rs_hit_o), 64'(0));
    model_cmp();
    @(posedge clk); #1;
    rst = 1'b0;
    rs_addr_i = '0;
    @(negedge clk);
    model_cmp();

    // Directed vector table
    for (int n = 0; n < 14; n++) begin
      step(vt[n].v, vt[n].a0, vt[n].d0, vt[n].a1, vt[n].d1, vt[n].r0, vt[n].r1, 1'b0);
      chk($sformatf("vec%0d_we", n), 64'(rf_we_o), 64'(vt[n].e_we));
      if (vt[n].e_we) begin
        chk($sformatf("vec%0d_waddr", n), 64'(rf_waddr_o), 64'(vt[n].e_wa));
        chk($sformatf("vec%0d_wdata", n), 64'(rf_wdata_o), 64'(vt[n].e_wd));
      end
      chk($sformatf("vec%0d_busy", n), 64'(busy_o), 64'(vt[n].e_busy));
      chk($sformatf("vec%0d_ready", n), 64'(ch_ready_o), 64'(2'b11));
      chk($sformatf("vec%0d_hit0", n), 64'(rs_hit_o[0]), 64'(vt[n].e_h0));
      chk($sformatf("vec%0d_data0", n), 64'(rs_data_o[0]), 64'(vt[n].e_d0));
      chk($sformatf("vec%0d_hit1", n), 64'(rs_hit_o[1]), 64'(vt[n].e_h1));
      chk($sformatf("vec%0d_data1", n), 64'(rs_data_o[1]), 64'(vt[n].e_d1));
    end

    // Backpressure: three back-to-back collisions fill the FIFO to 3 entries
    got_w.delete();
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        step(2'b11, 5'(11 + 2*c), 32'h100 + 32'(11 + 2*c), 5'(12 + 2*c), 32'h100 + 32'(12 + 2*c), 0, 0, 1'b0);
      end else begin
        step(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
      end
      if (c < 5) chk($sformatf("bp_ready_c%0d", c), 64'(ch_ready_o), (c == 3) ? 64'(2'b00) : 64'(2'b11));
    end
    chk("bp_busy_end", 64'(busy_o), 64'(0));
    chk("bp_nwrites", 64'(got_w.size()), 64'(6));
    for (int k = 0; k < 6 && k < got_w.size(); k++) begin
      chk($sformatf("bp_w%0d_addr", k), 64'(got_w[k].a), 64'(11 + k));
      chk($sformatf("bp_w%0d_data", k), 64'(got_w[k].d), 64'(32'h100 + 32'(11 + k)));
    end

    // Unstall pulse: stall high for cycles 3..5
    for (int k = 0; k < 10; k++) begin
      step(2'b00, 0, 0, 0, 0, 0, 0, (k >= 3 && k <= 5));
      chk($sformatf("unstall_c%0d", k), 64'(unstall_o), 64'(k == 7));
    end

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      rv  = 2'($urandom_range(0, 3));
      ra0 = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      rd0 = $urandom;
      rd1 = $urandom;
      rr0 = 5'($urandom_range(0, 7));
      rr1 = 5'($urandom_range(0, 7));
      rst_ = 1'($urandom_range(0, 1));
      step(rv, ra0, rd0, ra1, rd1, rr0, rr1, rst_);
    end

    // Reset mid-drain with three buffered results
    for (int k = 0; k < 6; k++) step(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(2'b11, 5'(20 + 2*c), 32'h200 + 32'(c), 5'(21 + 2*c), 32'h300 + 32'(c), 0, 0, 1'b0);
    end
    chk("mid_busy_before", 64'(busy_o), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    ch_valid_i = '0;
    rs_addr_i[0] = 5'd25;
    rs_addr_i[1] = 5'd23;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("mid_rst%0d_busy", k), 64'(busy_o), 64'(0));
      chk($sformatf("mid_rst%0d_we", k), 64'(rf_we_o), 64'(0));
      chk($sformatf("mid_rst%0d_ready", k), 64'(ch_ready_o), 64'(2'b11));
      chk($sformatf("mid_rst%0d_hit", k), 64'(rs_hit_o), 64'(0));
      model_cmp();
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    model_cmp();
    got_w.delete();
    for (int k = 0; k < 3; k++) step(2'b00, 0, 0, 0, 0, 25, 23, 1'b0);
    chk("mid_no_writes", 64'(got_w.size()), 64'(0));
    chk("mid_hit_after", 64'(rs_hit_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
